// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory responder for the CPU load/store port.
//
// Owns a 2^ADDR_W x 32-bit synchronous-read RAM. It accepts one request at a
// time, translates and checks the CPU address, merges byte/half stores into
// the stored word, and extends sub-word loads. Each request produces exactly
// one single-cycle response pulse.
//
// Ports:
//   clk_in      in   system clock; all state updates on the rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  idle and able to accept (transfer = req_valid & req_ready)
//   req_we      in   1 = store, 0 = load
//   req_size    in   00 byte, 01 half, 10 word, 11 illegal
//   req_signed  in   loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr    in   CPU byte address
//   req_wdata   in   store data (byte uses [7:0], half uses [15:0])
//   resp_valid  out  one-cycle response pulse
//   resp_rdata  out  extended load data; 0 for stores, errors and idle
//   resp_err    out  misaligned, out of range or illegal size (with resp_valid)

module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          ADDR_W    = 7
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LRESP, S_MERGE, S_WRITE, S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t              state;
    logic [31:0]         mem [2**ADDR_W];
    logic [31:0]         ram_q;

    // Fields captured on the accept cycle.
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [1:0]          lane_q;
    logic [31:0]         wdata_q;

    // Address translation; the subtraction wraps, so addresses below the base
    // land far above the RAM and fail the range test.
    logic [31:0]         req_offset;
    logic [ADDR_W-1:0]   req_idx;
    logic                req_bad;
    logic                accept;

    assign req_offset = req_addr - BASE_ADDR;
    assign req_idx    = req_offset[ADDR_W+1:2];
    assign accept     = !reset && (state == S_IDLE) && req_valid && req_ready;
    assign req_bad    = (req_offset[31:ADDR_W+2] != '0)
                     || (req_size == SZ_BAD)
                     || (req_size == SZ_HALF && req_offset[0])
                     || (req_size == SZ_WORD && req_offset[1:0] != 2'b00);

    // Lane extraction for loads and lane replacement for sub-word stores.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        sel_byte   = ram_q[{lane_q, 3'b000} +: 8];
        sel_half   = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
        load_data  = ram_q;
        merge_data = ram_q;
        case (size_q)
            SZ_BYTE: begin
                load_data = {{24{signed_q & sel_byte[7]}}, sel_byte};
                merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{signed_q & sel_half[15]}}, sel_half};
                merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // RAM: read is launched on the accept edge so the word is ready in READ;
    // writes happen in WRITE or MERGE and are suppressed by reset.
    // NOTE: the RAM array has no reset branch; clearing it would turn the
    // block RAM into a huge register file, and its contents must survive reset.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            ram_q <= mem[req_idx];
        end
        if (!reset && state == S_WRITE) begin
            mem[idx_q] <= wdata_q;
        end else if (!reset && state == S_MERGE) begin
            mem[idx_q] <= merge_data;
        end
    end

    // Control FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            idx_q      <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        idx_q     <= req_idx;
                        lane_q    <= req_offset[1:0];
                        wdata_q   <= req_wdata;
                        if (req_bad) begin
                            state      <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && req_size == SZ_WORD) begin
                            state      <= S_WRITE;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    resp_valid <= 1'b1;
                    if (we_q) begin
                        state <= S_MERGE;
                    end else begin
                        state      <= S_LRESP;
                        resp_rdata <= load_data;
                    end
                end
                default: begin
                    // LRESP, MERGE, WRITE, ERR: response is on the bus now.
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- directed self-checking bench for dmem_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_dmem_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_ctrl dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: wait for ready, transfer, then scramble the inputs and
    // measure accept-to-response latency in cycles.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        int wait_cnt = 0;
        @(negedge clk_in);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_signed = sgn; req_addr = addr; req_wdata = wdata;
        while (!req_ready && wait_cnt < 20) begin
            @(negedge clk_in);
            wait_cnt++;
        end
        if (wait_cnt >= 20) check("ready_timeout", 32'(req_ready), 32'd1);
        @(negedge clk_in);
        req_valid = 1'b0; req_we = ~we; req_size = 2'b10;
        req_signed = ~sgn; req_addr = 32'h1001_0040; req_wdata = ~wdata;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk_in);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n_acc, n_resp;
    int          acc_cyc [4];
    int          resp_cyc [4];
    logic [31:0] resp_dat [4];
    logic        saw_resp;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk_in);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk_in);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Word store then load.
        do_req(1, 2'b10, 0, 32'h1001_0008, 32'hDEAD_BEEF, rd, er, lat);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_err", 32'(er), 32'd0);
        check("sw_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h1001_0008, 32'h0, rd, er, lat);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_data", rd, 32'hDEAD_BEEF);

        // Byte store merge and byte extension.
        do_req(1, 2'b00, 0, 32'h1001_0009, 32'h1234_5680, rd, er, lat);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_err", 32'(er), 32'd0);
        check("sb_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h1001_0008, 32'h0, rd, er, lat);
        check("lw_after_sb", rd, 32'hDEAD_80EF);
        do_req(0, 2'b00, 1, 32'h1001_0009, 32'h0, rd, er, lat);
        check("lb_signed", rd, 32'hFFFF_FF80);
        do_req(0, 2'b00, 0, 32'h1001_0009, 32'h0, rd, er, lat);
        check("lbu", rd, 32'h0000_0080);

        // Half store at lane 2 and half extension.
        do_req(1, 2'b10, 0, 32'h1001_000C, 32'h1122_3344, rd, er, lat);
        do_req(1, 2'b01, 0, 32'h1001_000E, 32'hAAAA_8001, rd, er, lat);
        check("sh_lat", 32'(lat), 32'd2);
        do_req(0, 2'b01, 1, 32'h1001_000E, 32'h0, rd, er, lat);
        check("lh_signed", rd, 32'hFFFF_8001);
        do_req(0, 2'b01, 0, 32'h1001_000E, 32'h0, rd, er, lat);
        check("lhu", rd, 32'h0000_8001);
        do_req(0, 2'b10, 0, 32'h1001_000C, 32'h0, rd, er, lat);
        check("lw_after_sh", rd, 32'h8001_3344);

        // Error cases, each followed by a read-back of the aliased word.
        do_req(1, 2'b10, 0, 32'h1001_0000, 32'hCAFE_F00D, rd, er, lat);
        do_req(1, 2'b10, 0, 32'h1001_01FC, 32'h7777_AAAA, rd, er, lat);
        check("top_word_ok", 32'(er), 32'd0);

        do_req(0, 2'b01, 1, 32'h1001_0001, 32'h0, rd, er, lat);
        check("e_half_err", 32'(er), 32'd1);
        check("e_half_lat", 32'(lat), 32'd1);
        check("e_half_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h1001_0000, 32'h0, rd, er, lat);
        check("e_half_rb", rd, 32'hCAFE_F00D);

        do_req(1, 2'b10, 0, 32'h1001_0002, 32'h0BAD_BAD0, rd, er, lat);
        check("e_word_err", 32'(er), 32'd1);
        check("e_word_lat", 32'(lat), 32'd1);
        do_req(0, 2'b10, 0, 32'h1001_0000, 32'h0, rd, er, lat);
        check("e_word_rb", rd, 32'hCAFE_F00D);

        do_req(1, 2'b10, 0, 32'h1000_FFFC, 32'h5555_5555, rd, er, lat);
        check("e_below_err", 32'(er), 32'd1);
        do_req(0, 2'b10, 0, 32'h1001_01FC, 32'h0, rd, er, lat);
        check("e_below_rb", rd, 32'h7777_AAAA);

        do_req(1, 2'b10, 0, 32'h1001_0200, 32'h6666_6666, rd, er, lat);
        check("e_above_err", 32'(er), 32'd1);
        check("e_above_lat", 32'(lat), 32'd1);
        do_req(0, 2'b10, 0, 32'h1001_0000, 32'h0, rd, er, lat);
        check("e_above_rb", rd, 32'hCAFE_F00D);

        do_req(1, 2'b11, 0, 32'h1001_0000, 32'h4444_4444, rd, er, lat);
        check("e_size_err", 32'(er), 32'd1);
        check("e_size_rdata", rd, 32'd0);
        do_req(0, 2'b10, 0, 32'h1001_0000, 32'h0, rd, er, lat);
        check("e_size_rb", rd, 32'hCAFE_F00D);

        // Byte store aborted by reset during READ.
        @(negedge clk_in);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h1001_0008; req_wdata = 32'h0000_0099;
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk_in);
        req_valid = 1'b0;
        reset = 1'b1;
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            saw_resp = saw_resp | resp_valid;
        end
        check("abort_ready_in_rst", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk_in);
        saw_resp = saw_resp | resp_valid;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_no_resp", 32'(saw_resp), 32'd0);
        do_req(0, 2'b10, 0, 32'h1001_0008, 32'h0, rd, er, lat);
        check("abort_rb", rd, 32'hDEAD_80EF);

        // Two back-to-back loads with req_valid held high.
        n_acc = 0; n_resp = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h1001_0008; req_wdata = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (n_acc == 1) req_addr = 32'h1001_000C;
            if (n_acc >= 2) req_valid = 1'b0;
            if (resp_valid && n_resp < 4) begin
                resp_cyc[n_resp] = i;
                resp_dat[n_resp] = resp_rdata;
                n_resp++;
            end
            if (req_valid && req_ready && n_acc < 4) begin
                acc_cyc[n_acc] = i;
                n_acc++;
            end
        end
        check("b2b_accepts", 32'(n_acc), 32'd2);
        check("b2b_resps", 32'(n_resp), 32'd2);
        if (n_acc >= 2 && n_resp >= 2) begin
            check("b2b_gap", 32'(acc_cyc[1] - resp_cyc[0]), 32'd1);
            check("b2b_data0", resp_dat[0], 32'hDEAD_80EF);
            check("b2b_data1", resp_dat[1], 32'h8001_3344);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
